data_mem_resp: RTL and testbench
================================

DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 The module SHALL have parameter DEPTH, default 1024, giving memory size in 32-bit words; legal values are powers of two from 4 to 65536.
REQ-002 The module SHALL have parameter GNT_WAIT, default 0, giving wait cycles between request assertion and grant; legal values are 0 to 15.
REQ-003 The module SHALL have parameter RESP_LAT, default 1, giving cycles from handshake to response; legal values are 1 to 4.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock, rising edge active.
REQ-005 The module SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-006 The module SHALL have port data_req, input, 1 bit: initiator request valid.
REQ-007 The module SHALL have port data_we, input, 1 bit: 1 for write, 0 for read; qualified by data_req.
REQ-008 The module SHALL have port data_addr, input, 32 bits: byte address.
REQ-009 The module SHALL have port data_wdata, input, 32 bits: write data.
REQ-010 The module SHALL have port data_gnt, output, 1 bit: request accepted this cycle.
REQ-011 The module SHALL have port data_rvalid, output, 1 bit: response valid, a one-cycle pulse per accepted request.
REQ-012 The module SHALL have port data_rdata, output, 32 bits: read data.
REQ-013 The module SHALL have port data_err, output, 1 bit: response error flag, qualified by data_rvalid.

Function
REQ-014 A handshake SHALL occur on a rising clk edge where data_req=1 and data_gnt=1; at most one handshake per cycle.
REQ-015 data_gnt SHALL be combinational: data_gnt = data_req AND (wait_cnt == GNT_WAIT); with GNT_WAIT=0, data_gnt equals data_req.
REQ-016 wait_cnt (4 bits) SHALL increment each edge where data_req=1 and data_gnt=0, and clear to 0 on a handshake or on any edge with data_req=0.
REQ-017 Word index SHALL be data_addr[log2(DEPTH)+1:2]; the request is in error if data_addr[1:0]!=0 or data_addr[31:log2(DEPTH)+2]!=0.
REQ-018 Write handshake without error: mem[index] SHALL be updated with data_wdata at the handshake edge.
REQ-019 Read handshake without error: rdata SHALL be sampled from mem[index] at the handshake edge, so a read accepted in cycle N+1 returns data written at handshake N.
REQ-020 Errored request: memory SHALL NOT be modified, and the response SHALL carry data_err=1 and data_rdata=0.
REQ-021 Write responses SHALL carry data_rdata=0 and data_err per REQ-017.
REQ-022 Responses SHALL pass through a RESP_LAT-stage registered pipeline {valid, rdata, err}; a handshake at edge N SHALL produce data_rvalid=1 exactly in the cycle after edge N+RESP_LAT-1.
REQ-023 Responses SHALL return in request order, and back-to-back handshakes SHALL produce back-to-back rvalid pulses.
REQ-024 There SHALL be no response backpressure; up to RESP_LAT transactions may be outstanding, and grant SHALL NOT depend on outstanding count.
REQ-025 Outside response cycles, data_rvalid, data_err and data_rdata SHALL all be 0.
REQ-026 Input changes while data_req=0 SHALL have no effect.
REQ-027 Dropping data_req before grant SHALL cancel the request with no response generated.

Reset
REQ-028 While rst=1, data_gnt SHALL be 0 regardless of data_req, and no handshake SHALL occur.
REQ-029 rst=1 SHALL asynchronously clear wait_cnt and all pipeline stages, setting data_rvalid=0, data_err=0 and data_rdata=0.
REQ-030 Responses in flight when reset asserts SHALL be discarded and never emitted.
REQ-031 Memory contents SHALL NOT be reset; reads of never-written words return undefined data.
REQ-032 The first handshake SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-033 GNT_WAIT=0, RESP_LAT=1: write 0xDEADBEEF to 0x10 at edge 1, read 0x10 at edge 2 -> rvalid in cycles 2 and 3; cycle 3 rdata=0xDEADBEEF, err=0; cycle 2 rdata=0.
REQ-034 GNT_WAIT=3: hold data_req=1 from cycle 0 -> data_gnt low in cycles 0-2 and high in cycle 3; drop data_req at cycle 2 -> no grant and no rvalid.
REQ-035 RESP_LAT=3: four consecutive reads to 0x0, 0x4, 0x8, 0xC -> four consecutive rvalid pulses starting 3 cycles after the first handshake, in address order.
REQ-036 DEPTH=1024: write to 0x1002 (misaligned) and to 0x1000 (out of range) -> both respond with err=1 and rdata=0; a following read of 0x0 is unchanged.
REQ-037 RESP_LAT=4: assert rst two cycles after a read handshake -> no rvalid ever emitted for it; the first post-reset handshake responds normally.

Source files
------------

// File: rtl/data_mem_resp.sv
// data_mem_resp: single-port word memory behind a req/gnt data interface.
//
// A request is accepted (handshake) on a rising edge where data_req and
// data_gnt are both high. Grant is combinational and is held off for
// GNT_WAIT cycles of continuous request. Every accepted request produces
// exactly one data_rvalid pulse RESP_LAT cycles later, in request order,
// with no backpressure.
//
// Parameters
//   DEPTH    : memory size in 32-bit words (power of two, 4..65536)
//   GNT_WAIT : request-to-grant wait cycles (0..15)
//   RESP_LAT : handshake-to-response latency in cycles (1..4)
//
// Ports
//   clk         : clock, rising edge
//   rst         : asynchronous active-high reset
//   data_req    : request valid
//   data_we     : 1 = write, 0 = read
//   data_addr   : byte address
//   data_wdata  : write data
//   data_gnt    : request accepted this cycle
//   data_rvalid : one-cycle response pulse
//   data_rdata  : read data (0 for writes, errors and idle cycles)
//   data_err    : response error (misaligned or out-of-range address)
module data_mem_resp #(
    parameter int DEPTH    = 1024,
    parameter int GNT_WAIT = 0,
    parameter int RESP_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_req,
    input  logic        data_we,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_gnt,
    output logic        data_rvalid,
    output logic [31:0] data_rdata,
    output logic        data_err
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]                r_mem [DEPTH];
    logic [3:0]                 r_wait_cnt;
    logic [RESP_LAT-1:0]        r_vld;
    logic [RESP_LAT-1:0]        r_err;
    logic [RESP_LAT-1:0][31:0]  r_rdata;

    logic          w_hs;
    logic          w_err;
    logic [AW-1:0] w_idx;

    assign w_idx = data_addr[AW+1:2];
    // Any set bit above the word-index field addresses beyond the memory.
    assign w_err = (data_addr[1:0] != 2'b00) || ((data_addr >> (AW + 2)) != 32'd0);

    // Reset gates grant so nothing is accepted while rst is high.
    assign data_gnt = !rst && data_req && (r_wait_cnt == 4'(GNT_WAIT));
    assign w_hs     = data_gnt;

    // Counts cycles of an ungranted request; a dropped request restarts
    // the wait from zero, so cancelling leaves no residue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= 4'd0;
        end else if (!data_req || data_gnt) begin
            r_wait_cnt <= 4'd0;
        end else begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
        end
    end

    // Memory contents survive reset; only the response path is cleared.
    always_ff @(posedge clk) begin
        if (w_hs && data_we && !w_err) begin
            r_mem[w_idx] <= data_wdata;
        end
    end

    // Response pipeline. Stage 0 captures the handshake; idle cycles load
    // zeros so rdata/err are 0 whenever rvalid is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld   <= '0;
            r_err   <= '0;
            r_rdata <= '0;
        end else begin
            r_vld[0]   <= w_hs;
            r_err[0]   <= w_hs && w_err;
            r_rdata[0] <= (w_hs && !data_we && !w_err) ? r_mem[w_idx] : 32'd0;
            for (int i = 1; i < RESP_LAT; i++) begin
                r_vld[i]   <= r_vld[i-1];
                r_err[i]   <= r_err[i-1];
                r_rdata[i] <= r_rdata[i-1];
            end
        end
    end

    assign data_rvalid = r_vld[RESP_LAT-1];
    assign data_err    = r_err[RESP_LAT-1];
    assign data_rdata  = r_rdata[RESP_LAT-1];
endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench for data_mem_resp. Four instances cover the parameter
// points of interest: u0 defaults, u1 GNT_WAIT=3, u2 RESP_LAT=3,
// u3 RESP_LAT=4. Inputs change 1ns after the rising edge; outputs are
// sampled 2ns after the rising edge.
module tb_data_mem_resp;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [3:0]  we  = '0;
    logic [31:0] addr  [4];
    logic [31:0] wdata [4];
    logic [3:0]  gnt, rvalid, err;
    logic [31:0] rdata [4];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    data_mem_resp #(.DEPTH(1024), .GNT_WAIT(0), .RESP_LAT(1)) u0 (
        .clk(clk), .rst(rst), .data_req(req[0]), .data_we(we[0]),
        .data_addr(addr[0]), .data_wdata(wdata[0]), .data_gnt(gnt[0]),
        .data_rvalid(rvalid[0]), .data_rdata(rdata[0]), .data_err(err[0]));
    data_mem_resp #(.DEPTH(1024), .GNT_WAIT(3), .RESP_LAT(1)) u1 (
        .clk(clk), .rst(rst), .data_req(req[1]), .data_we(we[1]),
        .data_addr(addr[1]), .data_wdata(wdata[1]), .data_gnt(gnt[1]),
        .data_rvalid(rvalid[1]), .data_rdata(rdata[1]), .data_err(err[1]));
    data_mem_resp #(.DEPTH(1024), .GNT_WAIT(0), .RESP_LAT(3)) u2 (
        .clk(clk), .rst(rst), .data_req(req[2]), .data_we(we[2]),
        .data_addr(addr[2]), .data_wdata(wdata[2]), .data_gnt(gnt[2]),
        .data_rvalid(rvalid[2]), .data_rdata(rdata[2]), .data_err(err[2]));
    data_mem_resp #(.DEPTH(1024), .GNT_WAIT(0), .RESP_LAT(4)) u3 (
        .clk(clk), .rst(rst), .data_req(req[3]), .data_we(we[3]),
        .data_addr(addr[3]), .data_wdata(wdata[3]), .data_gnt(gnt[3]),
        .data_rvalid(rvalid[3]), .data_rdata(rdata[3]), .data_err(err[3]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Advance one edge; inputs may be driven immediately afterwards.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Let combinational grant settle after driving inputs.
    task automatic settle();
        #1;
    endtask

    task automatic drv(input int i, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
        req[i]   = r;
        we[i]    = w;
        addr[i]  = a;
        wdata[i] = d;
    endtask

    task automatic resp(input string tag, input int i, input logic v,
                        input logic [31:0] d, input logic e);
        chk({tag, ".rvalid"}, {31'd0, rvalid[i]}, {31'd0, v});
        chk({tag, ".rdata"},  rdata[i], d);
        chk({tag, ".err"},    {31'd0, err[i]}, {31'd0, e});
    endtask

    initial begin
        for (int i = 0; i < 4; i++) drv(i, 1'b0, 1'b0, 32'd0, 32'd0);

        // ---- reset: outputs idle, grant blocked even with req high
        step();
        drv(0, 1'b1, 1'b0, 32'h0, 32'h0);
        settle();
        chk("rst.gnt", {31'd0, gnt[0]}, 32'd0);
        resp("rst.out", 0, 1'b0, 32'd0, 1'b0);
        step();
        chk("rst.gnt2", {31'd0, gnt[0]}, 32'd0);
        drv(0, 1'b0, 1'b0, 32'h0, 32'h0);
        rst = 1'b0;

        // ---- write then read back-to-back, RESP_LAT=1
        drv(0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
        settle();
        chk("wr.gnt", {31'd0, gnt[0]}, 32'd1);
        step();
        drv(0, 1'b1, 1'b0, 32'h10, 32'h0);
        settle();
        resp("wr.resp", 0, 1'b1, 32'd0, 1'b0);
        step();
        drv(0, 1'b0, 1'b0, 32'h0, 32'h0);
        settle();
        resp("rd.resp", 0, 1'b1, 32'hDEADBEEF, 1'b0);
        step();
        settle();
        resp("idle", 0, 1'b0, 32'd0, 1'b0);

        // ---- error addresses alias word 0 but must not write it
        drv(0, 1'b1, 1'b1, 32'h0, 32'h12345678);
        step();
        drv(0, 1'b1, 1'b1, 32'h1002, 32'hAAAA0000);
        step();
        drv(0, 1'b1, 1'b1, 32'h1000, 32'hBBBB0000);
        settle();
        resp("mis.resp", 0, 1'b1, 32'd0, 1'b1);
        step();
        // inputs wiggle with req low: no effect
        drv(0, 1'b0, 1'b1, 32'h0, 32'hCCCC0000);
        settle();
        resp("oor.resp", 0, 1'b1, 32'd0, 1'b1);
        step();
        drv(0, 1'b1, 1'b0, 32'h0, 32'h0);
        settle();
        resp("noreq.idle", 0, 1'b0, 32'd0, 1'b0);
        step();
        drv(0, 1'b0, 1'b0, 32'h0, 32'h0);
        settle();
        resp("rd0.resp", 0, 1'b1, 32'h12345678, 1'b0);
        step();

        // ---- GNT_WAIT=3: grant in the fourth cycle of a held request
        drv(1, 1'b1, 1'b0, 32'h4, 32'h0);
        settle();
        chk("gw.c0", {31'd0, gnt[1]}, 32'd0);
        step(); settle();
        chk("gw.c1", {31'd0, gnt[1]}, 32'd0);
        step(); settle();
        chk("gw.c2", {31'd0, gnt[1]}, 32'd0);
        step(); settle();
        chk("gw.c3", {31'd0, gnt[1]}, 32'd1);
        chk("gw.c3.rv", {31'd0, rvalid[1]}, 32'd0);
        step();
        drv(1, 1'b0, 1'b0, 32'h0, 32'h0);
        settle();
        chk("gw.rv", {31'd0, rvalid[1]}, 32'd1);
        chk("gw.err", {31'd0, err[1]}, 32'd0);
        step(); settle();
        chk("gw.rv0", {31'd0, rvalid[1]}, 32'd0);

        // dropped at cycle 2: cancelled, and the wait restarts from zero
        drv(1, 1'b1, 1'b0, 32'h4, 32'h0);
        step();
        step();
        drv(1, 1'b0, 1'b0, 32'h4, 32'h0);
        for (int k = 0; k < 4; k++) begin
            settle();
            chk($sformatf("gw.cancel.gnt%0d", k), {31'd0, gnt[1]}, 32'd0);
            chk($sformatf("gw.cancel.rv%0d", k), {31'd0, rvalid[1]}, 32'd0);
            step();
        end
        drv(1, 1'b1, 1'b0, 32'h4, 32'h0);
        step(); settle();
        chk("gw.restart1", {31'd0, gnt[1]}, 32'd0);
        step(); settle();
        chk("gw.restart2", {31'd0, gnt[1]}, 32'd0);
        drv(1, 1'b0, 1'b0, 32'h0, 32'h0);

        // ---- RESP_LAT=3: four back-to-back reads return in order
        for (int k = 0; k < 4; k++) begin
            drv(2, 1'b1, 1'b1, 32'(4 * k), 32'h100 + 32'(k));
            step();
        end
        drv(2, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int k = 0; k < 4; k++) step();
        drv(2, 1'b1, 1'b0, 32'h0, 32'h0);
        step();
        drv(2, 1'b1, 1'b0, 32'h4, 32'h0);
        settle();
        chk("rl3.e1", {31'd0, rvalid[2]}, 32'd0);
        step();
        drv(2, 1'b1, 1'b0, 32'h8, 32'h0);
        settle();
        chk("rl3.e2", {31'd0, rvalid[2]}, 32'd0);
        step();
        drv(2, 1'b1, 1'b0, 32'hC, 32'h0);
        settle();
        resp("rl3.r0", 2, 1'b1, 32'h100, 1'b0);
        step();
        drv(2, 1'b0, 1'b0, 32'h0, 32'h0);
        settle();
        resp("rl3.r1", 2, 1'b1, 32'h101, 1'b0);
        step(); settle();
        resp("rl3.r2", 2, 1'b1, 32'h102, 1'b0);
        step(); settle();
        resp("rl3.r3", 2, 1'b1, 32'h103, 1'b0);
        step(); settle();
        resp("rl3.idle", 2, 1'b0, 32'd0, 1'b0);

        // ---- RESP_LAT=4: reset kills an in-flight read
        drv(3, 1'b1, 1'b1, 32'h20, 32'hCAFEF00D);
        step();
        drv(3, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int k = 0; k < 5; k++) step();
        drv(3, 1'b1, 1'b0, 32'h20, 32'h0);
        step();                         // read handshake H
        drv(3, 1'b0, 1'b0, 32'h0, 32'h0);
        step();                         // H+1
        step();                         // H+2
        rst = 1'b1;
        drv(3, 1'b1, 1'b0, 32'h20, 32'h0);
        settle();
        resp("rl4.rst.out", 3, 1'b0, 32'd0, 1'b0);
        chk("rl4.rst.gnt", {31'd0, gnt[3]}, 32'd0);
        step();
        step();
        settle();
        chk("rl4.rst.rv", {31'd0, rvalid[3]}, 32'd0);
        rst = 1'b0;
        settle();
        chk("rl4.post.gnt", {31'd0, gnt[3]}, 32'd1);
        step();                         // first post-reset handshake
        drv(3, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            settle();
            chk($sformatf("rl4.post.wait%0d", k), {31'd0, rvalid[3]}, 32'd0);
            step();
        end
        settle();
        resp("rl4.post.resp", 3, 1'b1, 32'hCAFEF00D, 1'b0);
        step(); settle();
        resp("rl4.post.idle", 3, 1'b0, 32'd0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
